// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two requesters (execute and load writeback)
// share one register-file write port. Round-robin on contention, one-cycle
// registered write port, x0 writes swallowed, and read-stage forwarding of the
// write currently on the port.
//
// last_grant | meaning
// GNT_A      | requester A won the most recent transfer (B wins next contention)
// GNT_B      | requester B won the most recent transfer (A wins next contention)
module regfile_wb_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_valid,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              w_ena,
  output logic [4:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [4:0]        q_addr1,
  input  logic [4:0]        q_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  grant_e last_grant;
  logic   grant_a;
  logic   grant_b;

  // Grant decision: single requester wins outright, contention goes to the
  // side that did not win last time; flush and reset block every transfer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !flush) begin
      if (a_valid && b_valid) begin
        if (last_grant == GNT_B) grant_a = 1'b1;
        else                     grant_b = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Round-robin history only moves on an actual transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_grant <= GNT_B;
    else if (grant_a) last_grant <= GNT_A;
    else if (grant_b) last_grant <= GNT_B;
  end

  // Write port register: one-cycle pulse per transfer; x0 loads addr/data but
  // keeps the enable low so the architectural zero register is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ena  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (grant_a) begin
      w_ena  <= (a_addr != 5'd0);
      w_addr <= a_addr;
      w_data <= a_data;
    end else if (grant_b) begin
      w_ena  <= (b_addr != 5'd0);
      w_addr <= b_addr;
      w_data <= b_data;
    end else begin
      w_ena  <= 1'b0;
    end
  end

  // Forwarding straight from the output registers; w_ena is already 0 while
  // in reset so the hits are forced low without extra gating.
  assign fwd_hit1  = w_ena && (w_addr == q_addr1) && (q_addr1 != 5'd0);
  assign fwd_hit2  = w_ena && (w_addr == q_addr2) && (q_addr2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? w_data : '0;
  assign fwd_data2 = fwd_hit2 ? w_data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              a_valid;
  logic [4:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              w_ena;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic [4:0]        q_addr1;
  logic [4:0]        q_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who wins this cycle, and what the write port shows.
  bit              m_last_b = 1'b1;
  bit              m_wena   = 1'b0;
  logic [4:0]      m_waddr  = '0;
  logic [63:0]     m_wdata  = '0;

  initial begin
    forever begin
      int win;
      logic [4:0]  q1;
      logic [4:0]  q2;
      bit          h1;
      bit          h2;
      @(negedge clk);
      win = 0;
      if (rst) begin
        m_last_b = 1'b1;
        m_wena   = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
      end else if (!flush) begin
        if (a_valid && b_valid) win = m_last_b ? 1 : 2;
        else if (a_valid)       win = 1;
        else if (b_valid)       win = 2;
      end
      q1 = q_addr1;
      q2 = q_addr2;
      h1 = m_wena && (q1 != 0) && (q1 == m_waddr);
      h2 = m_wena && (q2 != 0) && (q2 == m_waddr);
      chk("a_ready", a_ready, 64'(win == 1));
      chk("b_ready", b_ready, 64'(win == 2));
      chk("w_ena", w_ena, 64'(m_wena));
      chk("w_addr", w_addr, 64'(m_waddr));
      chk("w_data", w_data, m_wdata);
      chk("fwd_hit1", fwd_hit1, 64'(h1));
      chk("fwd_hit2", fwd_hit2, 64'(h2));
      chk("fwd_data1", fwd_data1, h1 ? m_wdata : 64'd0);
      chk("fwd_data2", fwd_data2, h2 ? m_wdata : 64'd0);
      if (win == 1) begin
        m_wena = (a_addr != 0); m_waddr = a_addr; m_wdata = a_data; m_last_b = 1'b0;
      end else if (win == 2) begin
        m_wena = (b_addr != 0); m_waddr = b_addr; m_wdata = b_data; m_last_b = 1'b1;
      end else begin
        m_wena = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; a_valid = 0; b_valid = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    q_addr1 = 0; q_addr2 = 0;
  endtask

  initial begin
    int pulses;
    bit a_fire;
    bit b_fire;
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_w_ena", w_ena, 64'd0);
    chk("rst_w_addr", w_addr, 64'd0);
    chk("rst_w_data", w_data, 64'd0);
    chk("rst_a_ready", a_ready, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention right after reset: A first, then B.
    a_valid = 1; a_addr = 5; a_data = 64'h11;
    b_valid = 1; b_addr = 6; b_data = 64'h22;
    @(negedge clk);
    chk("s1_c0_a_ready", a_ready, 64'd1);
    chk("s1_c0_b_ready", b_ready, 64'd0);
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    chk("s1_c1_w_ena", w_ena, 64'd1);
    chk("s1_c1_w_addr", w_addr, 64'd5);
    chk("s1_c1_w_data", w_data, 64'h11);
    chk("s1_c1_b_ready", b_ready, 64'd1);
    next_cycle();
    b_valid = 0;
    @(negedge clk);
    chk("s1_c2_w_addr", w_addr, 64'd6);
    chk("s1_c2_w_data", w_data, 64'h22);
    next_cycle();

    // Sustained contention: strict alternation, one pulse per grant, in order.
    a_valid = 1; a_addr = 10; a_data = 64'h100;
    b_valid = 1; b_addr = 20; b_data = 64'h200;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        chk("s2_a_ready", a_ready, 64'((i % 2) == 0));
        chk("s2_b_ready", b_ready, 64'((i % 2) == 1));
      end
      if (i >= 1) begin
        if (w_ena) pulses++;
        if (i <= 8)
          chk("s2_w_data", w_data, ((i - 1) % 2 == 0) ? 64'h100 + 64'((i - 1) / 2)
                                                       : 64'h200 + 64'((i - 1) / 2));
      end
      next_cycle();
      if (i < 8) begin
        if ((i % 2) == 0) begin a_data = a_data + 1; a_addr = a_addr + 1; end
        else              begin b_data = b_data + 1; b_addr = b_addr + 1; end
      end
      if (i == 7) begin a_valid = 0; b_valid = 0; end
    end
    chk("s2_pulses", 64'(pulses), 64'd8);

    // x0 write completes handshake but never enables.
    b_valid = 1; b_addr = 0; b_data = 64'hFF;
    @(negedge clk);
    chk("s3_b_ready", b_ready, 64'd1);
    next_cycle();
    b_valid = 0;
    @(negedge clk);
    chk("s3_w_ena", w_ena, 64'd0);
    chk("s3_w_data", w_data, 64'hFF);
    next_cycle();

    // Flush blocks the transfer; it goes through once flush drops.
    a_valid = 1; a_addr = 7; a_data = 64'h77; flush = 1;
    @(negedge clk);
    chk("s4_a_ready_flush", a_ready, 64'd0);
    next_cycle();
    flush = 0;
    @(negedge clk);
    chk("s4_w_ena_after_flush", w_ena, 64'd0);
    chk("s4_a_ready", a_ready, 64'd1);
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    chk("s4_w_ena", w_ena, 64'd1);
    chk("s4_w_addr", w_addr, 64'd7);
    next_cycle();

    // Forwarding of the write on the port.
    a_valid = 1; a_addr = 9; a_data = 64'hABCD; q_addr1 = 9; q_addr2 = 0;
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    chk("s5_fwd_hit1", fwd_hit1, 64'd1);
    chk("s5_fwd_data1", fwd_data1, 64'hABCD);
    chk("s5_fwd_hit2", fwd_hit2, 64'd0);
    chk("s5_fwd_data2", fwd_data2, 64'd0);
    next_cycle();

    // Asynchronous reset between edges while a write is on the port.
    a_valid = 1; a_addr = 12; a_data = 64'h55;
    next_cycle();
    a_valid = 1; a_addr = 3; a_data = 64'h33;
    #2;
    chk("s6_w_ena_pre", w_ena, 64'd1);
    rst = 1;
    #1;
    chk("s6_w_ena", w_ena, 64'd0);
    chk("s6_w_addr", w_addr, 64'd0);
    chk("s6_w_data", w_data, 64'd0);
    chk("s6_a_ready", a_ready, 64'd0);
    next_cycle();
    chk("s6_a_ready_hold", a_ready, 64'd0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("s6_a_ready_release", a_ready, 64'd1);
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    chk("s6_w_ena_release", w_ena, 64'd1);
    chk("s6_w_addr_release", w_addr, 64'd3);
    next_cycle();
    idle_inputs();

    // Randomized traffic; requesters hold their offer until it transfers.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      @(posedge clk);
      if (i == 1500) begin
        #3 rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        a_fire = 0;
        b_fire = 0;
      end else begin
        #1;
      end
      if (!a_valid || a_fire) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || b_fire) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        b_data  = {$urandom, $urandom};
      end
      flush   = ($urandom_range(0, 7) == 0);
      q_addr1 = ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom_range(0, 31));
      q_addr2 = ($urandom_range(0, 2) == 0) ? m_waddr : 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
